snd_cmd_mailbox: RTL and testbench

Parametrised main-to-sound CPU command mailbox: a DEPTH-entry FIFO of DW-bit commands that replaces the single sound-command latch plus SndInt flag on board 1. The main Z80 pushes with nSNDCMD. The sound Z80 pops with a decoded I/O read and acknowledges its interrupt with M1+IORQ. A delayed interrupt copy gates the CTC vector path, replacing the ad-hoc sndint_delay/sndint_d2 chain. Everything runs on clk12m, with cpu_ce and snd_ce as the two CPU clock enables.

---
 rtl/snd_cmd_pkg.sv | 13 +
 rtl/snd_cmd_mailbox_strobe_edge.sv | 30 +++
 rtl/snd_cmd_mailbox.sv | 124 ++++++++++++
 tb/tb_snd_cmd_mailbox.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/snd_cmd_pkg.sv
// Shared constants and sizing helper for the sound-command mailbox.
// Combinational only; no flow control.
package snd_cmd_pkg;

  // Edge history resets to "already at the post-edge level", so a held strobe cannot fire.
  localparam logic EDGE_HIST_RST = 1'b1;
  localparam int   HOLD_RST      = 0;

  function automatic int CNT_W(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/snd_cmd_mailbox_strobe_edge.sv
// One-cycle event on a qualified edge of a strobe; history sampled only on ce.
// Latency: event is combinational from the strobe at the ce edge; no backpressure.
module strobe_edge
  import snd_cmd_pkg::*;
#(
  parameter bit RISE = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ce,
  input  logic strobe,
  output logic evt
);

  logic at_lvl;
  logic hist_q;

  // at_lvl is true once the strobe sits on the level reached after the edge of interest
  assign at_lvl = RISE ? strobe : ~strobe;
  assign evt    = ce & at_lvl & ~hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= EDGE_HIST_RST;
    end else if (ce) begin
      hist_q <= at_lvl;
    end
  end

endmodule

// File: rtl/snd_cmd_mailbox.sv
// Main-to-sound CPU command FIFO with interrupt and delayed vector-gate flag.
// Latency 1 clk12m per event; full pushes drop, or overwrite newest with SNDCMD_OVERWRITE_EN.
module snd_cmd_mailbox
  import snd_cmd_pkg::*;
#(
  parameter int DW      = 8,
  parameter int DEPTH   = 4,
  parameter int VEC_DLY = 2
) (
  input  logic                     clk12m,
  input  logic                     nRESET,
  input  logic                     cpu_ce,
  input  logic                     snd_ce,
  input  logic                     nSNDCMD,
  input  logic [DW-1:0]            cmd_din,
  input  logic                     snd_rd_n,
  input  logic                     int_ack_n,
  output logic [DW-1:0]            cmd_dout,
  output logic                     snd_int,
  output logic                     snd_int_dly,
  output logic [CNT_W(DEPTH)-1:0]  count,
  output logic                     overflow
);

  localparam int CW = CNT_W(DEPTH);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic          push_evt, rd_end_evt, ack_evt;
  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] hold_q;
  logic          snd_int_q, snd_int_d;
  logic          ovf_q;
  logic [VEC_DLY-1:0] dly_q, dly_d;
  logic [VEC_DLY:0]   dly_shf;
  logic          empty, full, do_pop, do_wr, ovf_evt;

  strobe_edge #(.RISE(1'b0)) u_push (
    .clk(clk12m), .rst_n(nRESET), .ce(cpu_ce), .strobe(nSNDCMD), .evt(push_evt)
  );
  strobe_edge #(.RISE(1'b1)) u_pop (
    .clk(clk12m), .rst_n(nRESET), .ce(snd_ce), .strobe(snd_rd_n), .evt(rd_end_evt)
  );
  strobe_edge #(.RISE(1'b0)) u_ack (
    .clk(clk12m), .rst_n(nRESET), .ce(snd_ce), .strobe(int_ack_n), .evt(ack_evt)
  );

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    do_pop   = rd_end_evt & ~empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands
    do_wr    = push_evt & (~full | do_pop);
    ovf_evt  = push_evt & full & ~do_pop;
    wr_ptr_d = do_wr  ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (do_wr && !do_pop) begin
      count_d = count_q + CW'(1);
    end else if (!do_wr && do_pop) begin
      count_d = count_q - CW'(1);
    end
    snd_int_d = push_evt | (do_pop & (count_d != '0)) | (snd_int_q & ~ack_evt);
    dly_shf   = {dly_q, snd_int_q};
    dly_d     = dly_shf[VEC_DLY-1:0];
  end

`ifdef SNDCMD_OVERWRITE_EN
  logic [PW-1:0] last_ptr;
  assign last_ptr = (wr_ptr_q == '0) ? PW'(DEPTH - 1) : wr_ptr_q - PW'(1);
`endif

  always_ff @(posedge clk12m or negedge nRESET) begin
    if (!nRESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_wr) begin
      mem_q[wr_ptr_q] <= cmd_din;
`ifdef SNDCMD_OVERWRITE_EN
    end else if (ovf_evt) begin
      mem_q[last_ptr] <= cmd_din;
`endif
    end
  end

  always_ff @(posedge clk12m or negedge nRESET) begin
    if (!nRESET) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      hold_q    <= DW'(HOLD_RST);
      snd_int_q <= 1'b0;
      ovf_q     <= 1'b0;
      dly_q     <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      snd_int_q <= snd_int_d;
      if (do_pop) begin
        hold_q <= mem_q[rd_ptr_q];
      end
      if (ovf_evt) begin
        ovf_q <= 1'b1;
      end
      if (snd_ce) begin
        dly_q <= dly_d;
      end
    end
  end

  assign cmd_dout    = empty ? hold_q : mem_q[rd_ptr_q];
  assign snd_int     = snd_int_q;
  assign snd_int_dly = dly_q[VEC_DLY-1];
  assign count       = count_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_snd_cmd_mailbox.sv
// Directed bench for snd_cmd_mailbox at DW=8, DEPTH=4, VEC_DLY=2.
module tb_snd_cmd_mailbox;

  logic       clk12m = 1'b0;
  logic       nRESET, cpu_ce, snd_ce, nSNDCMD, snd_rd_n, int_ack_n;
  logic [7:0] cmd_din;
  logic [7:0] cmd_dout;
  logic       snd_int, snd_int_dly, overflow;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;

  snd_cmd_mailbox #(.DW(8), .DEPTH(4), .VEC_DLY(2)) dut (
    .clk12m(clk12m), .nRESET(nRESET), .cpu_ce(cpu_ce), .snd_ce(snd_ce),
    .nSNDCMD(nSNDCMD), .cmd_din(cmd_din), .snd_rd_n(snd_rd_n), .int_ack_n(int_ack_n),
    .cmd_dout(cmd_dout), .snd_int(snd_int), .snd_int_dly(snd_int_dly),
    .count(count), .overflow(overflow)
  );

  always #5 clk12m = ~clk12m;

  task automatic tick();
    @(posedge clk12m);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    cmd_din = b; nSNDCMD = 1'b0; cpu_ce = 1'b1;
    tick();
    nSNDCMD = 1'b1;
    tick();
    cpu_ce = 1'b0;
  endtask

  task automatic pop();
    snd_rd_n = 1'b0; snd_ce = 1'b1;
    tick();
    snd_rd_n = 1'b1;
    tick();
    snd_ce = 1'b0;
  endtask

  task automatic ack();
    int_ack_n = 1'b0; snd_ce = 1'b1;
    tick();
    int_ack_n = 1'b1;
    tick();
    snd_ce = 1'b0;
  endtask

  task automatic snd_ticks(input int n);
    snd_ce = 1'b1;
    repeat (n) tick();
    snd_ce = 1'b0;
  endtask

  task automatic idle_ce();
    cpu_ce = 1'b1; snd_ce = 1'b1;
    repeat (2) tick();
    cpu_ce = 1'b0; snd_ce = 1'b0;
  endtask

  initial begin
    logic [7:0] last_exp;
    nRESET = 1'b0; cpu_ce = 1'b0; snd_ce = 1'b0;
    nSNDCMD = 1'b1; snd_rd_n = 1'b1; int_ack_n = 1'b1; cmd_din = 8'h00;
    repeat (3) tick();
    check("rst_count", 32'(count), 32'd0);
    check("rst_dout", 32'(cmd_dout), 32'h00);
    check("rst_int", 32'(snd_int), 32'd0);
    check("rst_dly", 32'(snd_int_dly), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    nRESET = 1'b1;
    tick();
    idle_ce();

    // two commands queued, first one visible
    push(8'h12);
    push(8'h34);
    check("push2_count", 32'(count), 32'd2);
    check("push2_dout", 32'(cmd_dout), 32'h12);
    check("push2_int", 32'(snd_int), 32'd1);
    check("push2_dly0", 32'(snd_int_dly), 32'd0);
    snd_ticks(1);
    check("dly_1tick", 32'(snd_int_dly), 32'd0);
    snd_ticks(1);
    check("dly_2tick", 32'(snd_int_dly), 32'd1);

    ack();
    check("ack_int", 32'(snd_int), 32'd0);
    pop();
    check("pop1_count", 32'(count), 32'd1);
    check("pop1_dout", 32'(cmd_dout), 32'h34);
    check("pop1_rearm", 32'(snd_int), 32'd1);
    ack();
    pop();
    check("pop2_count", 32'(count), 32'd0);
    check("pop2_hold", 32'(cmd_dout), 32'h34);
    check("pop2_int", 32'(snd_int), 32'd0);
    pop();
    check("pop_empty_count", 32'(count), 32'd0);
    check("pop_empty_dout", 32'(cmd_dout), 32'h34);

    // overfill by one
    for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
    check("ovf_count", 32'(count), 32'd4);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_int", 32'(snd_int), 32'd1);
    check("ovf_pop0", 32'(cmd_dout), 32'hA0);
    pop();
    check("ovf_pop1", 32'(cmd_dout), 32'hA1);
    pop();
    check("ovf_pop2", 32'(cmd_dout), 32'hA2);
    pop();
`ifdef SNDCMD_OVERWRITE_EN
    last_exp = 8'hA4;
`else
    last_exp = 8'hA3;
`endif
    check("ovf_pop3", 32'(cmd_dout), 32'(last_exp));
    pop();
    check("ovf_drain_count", 32'(count), 32'd0);
    check("ovf_drain_hold", 32'(cmd_dout), 32'(last_exp));
    check("ovf_sticky", 32'(overflow), 32'd1);

    // asynchronous reset with three queued, strobes held low across release
    push(8'hB0); push(8'hB1); push(8'hB2);
    check("pre_rst_count", 32'(count), 32'd3);
    check("pre_rst_int", 32'(snd_int), 32'd1);
    nSNDCMD = 1'b0; int_ack_n = 1'b0; snd_rd_n = 1'b0;
    nRESET = 1'b0;
    #1;
    check("arst_count", 32'(count), 32'd0);
    check("arst_dout", 32'(cmd_dout), 32'h00);
    check("arst_int", 32'(snd_int), 32'd0);
    check("arst_dly", 32'(snd_int_dly), 32'd0);
    check("arst_ovf", 32'(overflow), 32'd0);
    tick();
    cpu_ce = 1'b1; snd_ce = 1'b1;
    nRESET = 1'b1;
    repeat (3) tick();
    check("held_low_count", 32'(count), 32'd0);
    check("held_low_int", 32'(snd_int), 32'd0);
    nSNDCMD = 1'b1; int_ack_n = 1'b1; snd_rd_n = 1'b1;
    repeat (2) tick();
    cpu_ce = 1'b0; snd_ce = 1'b0;
    check("release_count", 32'(count), 32'd0);

    // push and pop on the same edge while full
    for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i));
    check("full_count", 32'(count), 32'd4);
    snd_rd_n = 1'b0; snd_ce = 1'b1;
    tick();
    cmd_din = 8'hC4; nSNDCMD = 1'b0; cpu_ce = 1'b1; snd_rd_n = 1'b1;
    tick();
    snd_ce = 1'b0; nSNDCMD = 1'b1;
    tick();
    cpu_ce = 1'b0;
    check("simul_count", 32'(count), 32'd4);
    check("simul_ovf", 32'(overflow), 32'd0);
    check("simul_pop0", 32'(cmd_dout), 32'hC1);
    pop();
    check("simul_pop1", 32'(cmd_dout), 32'hC2);
    pop();
    check("simul_pop2", 32'(cmd_dout), 32'hC3);
    pop();
    check("simul_pop3", 32'(cmd_dout), 32'hC4);
    pop();
    check("simul_drain", 32'(count), 32'd0);

    // long low strobe is a single push
    cmd_din = 8'hD5; nSNDCMD = 1'b0; cpu_ce = 1'b1;
    repeat (20) tick();
    nSNDCMD = 1'b1;
    tick();
    cpu_ce = 1'b0;
    check("long_strobe_count", 32'(count), 32'd1);
    check("long_strobe_dout", 32'(cmd_dout), 32'hD5);
    check("long_strobe_ovf", 32'(overflow), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
